rx_bit_checker: RTL and testbench



---
 rtl/rx_bit_checker.sv | 179 +++++++++++++++++
 tb/tb_rx_bit_checker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rx_bit_checker.sv
// Receive-side bit-error checker: aligns to a repeating 8-bit pattern,
// then counts locked bits and errors until the bit budget is reached.
module rx_bit_checker #(
  parameter logic [7:0]  PATTERN     = 8'hAA,
  parameter logic [31:0] MAX_BITS    = 32'h4C4B400,
  parameter int          LOCK_BITS   = 16,
  parameter int          LOSS_ERRORS = 8,
  parameter logic [31:0] ERR_LIMIT   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_bit_data,
  input  logic        rx_bit_valid,
  output logic        locked,
  output logic [31:0] rx_count,
  output logic [31:0] err_count,
  output logic        done,
  output logic        pass
);

  localparam logic [15:0] LOCK_N = 16'(LOCK_BITS);
  localparam logic [7:0]  LOSS_N = 8'(LOSS_ERRORS);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED, DONE} state_t;

  state_t      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  hunt_q, hunt_d;
  logic [15:0] match_q, match_d;
  logic [7:0]  miss_q, miss_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] err_q, err_d;
  logic        locked_q, locked_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;

  logic [7:0]  sr_shift;
  logic        bit_ok;
  logic [3:0]  hunt_inc;
  logic [15:0] match_inc;
  logic [31:0] rx_inc;
  logic [31:0] err_nx;
  logic [7:0]  miss_nx;
  logic        rot_hit;
  logic [2:0]  rot_r;
  logic        hunt_hit;
  logic        lost;
  logic        fin;

  function automatic logic [7:0] rol8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  always_comb begin
    sr_shift  = {sr_q[6:0], rx_bit_data};
    bit_ok    = (rx_bit_data == PATTERN[idx_q]);
    hunt_inc  = (hunt_q == 4'd8) ? 4'd8 : hunt_q + 4'd1;
    match_inc = match_q + 16'd1;
    rx_inc    = rx_q + 32'd1;
    err_nx    = (bit_ok || (&err_q)) ? err_q : err_q + 32'd1;
    miss_nx   = bit_ok ? 8'd0 : miss_q + 8'd1;
    lost      = (miss_nx == LOSS_N);
    fin       = (rx_inc == MAX_BITS);
    // Descending scan so the lowest matching rotation wins.
    rot_hit   = 1'b0;
    rot_r     = 3'd0;
    for (int r = 7; r >= 0; r--) begin
      if (sr_shift == rol8(PATTERN, r)) begin
        rot_hit = 1'b1;
        rot_r   = 3'(r);
      end
    end
    hunt_hit = (hunt_inc == 4'd8) && rot_hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      sr_q     <= '0;
      idx_q    <= '0;
      hunt_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      rx_q     <= '0;
      err_q    <= '0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      idx_q    <= idx_d;
      hunt_q   <= hunt_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      rx_q     <= rx_d;
      err_q    <= err_d;
      locked_q <= locked_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (rx_bit_valid) begin
      unique case (state_q)
        HUNT:    if (hunt_hit) state_d = VERIFY;
        VERIFY: begin
          if (!bit_ok)                  state_d = HUNT;
          else if (match_inc == LOCK_N) state_d = LOCKED;
        end
        LOCKED: begin
          if (fin)       state_d = DONE;
          else if (lost) state_d = HUNT;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sr_d     = sr_q;
    idx_d    = idx_q;
    hunt_d   = hunt_q;
    match_d  = match_q;
    miss_d   = miss_q;
    rx_d     = rx_q;
    err_d    = err_q;
    locked_d = locked_q;
    done_d   = done_q;
    pass_d   = pass_q;
    if (rx_bit_valid && state_q != DONE) begin
      sr_d  = sr_shift;
      idx_d = idx_q - 3'd1;
      unique case (state_q)
        HUNT: begin
          hunt_d = hunt_inc;
          if (hunt_hit) begin
            idx_d   = 3'd7 - rot_r;
            match_d = '0;
          end
        end
        VERIFY: begin
          if (!bit_ok) begin
            hunt_d = '0;
          end else begin
            match_d = match_inc;
            if (match_inc == LOCK_N) begin
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end
        end
        LOCKED: begin
          rx_d   = rx_inc;
          err_d  = err_nx;
          miss_d = miss_nx;
          if (fin) begin
            done_d = 1'b1;
            pass_d = (err_nx <= ERR_LIMIT);
          end else if (lost) begin
            locked_d = 1'b0;
            hunt_d   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign locked    = locked_q;
  assign rx_count  = rx_q;
  assign err_count = err_q;
  assign done      = done_q;
  assign pass      = pass_q;

endmodule

// File: tb/tb_rx_bit_checker.sv
// Directed bench for rx_bit_checker with small budgets.
module tb_rx_bit_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx_bit_data = 1'b0;
  logic        rx_bit_valid = 1'b0;
  logic        locked;
  logic [31:0] rx_count;
  logic [31:0] err_count;
  logic        done;
  logic        pass;

  int total = 0;
  int bad = 0;
  logic ph = 1'b1;
  logic gap = 1'b0;

  rx_bit_checker #(
    .PATTERN(8'hAA),
    .MAX_BITS(32'd100),
    .LOCK_BITS(16),
    .LOSS_ERRORS(4),
    .ERR_LIMIT(32'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_bit_data(rx_bit_data),
    .rx_bit_valid(rx_bit_valid),
    .locked(locked),
    .rx_count(rx_count),
    .err_count(err_count),
    .done(done),
    .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic b, input logic v);
    @(negedge clk);
    rx_bit_data  = b;
    rx_bit_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic clean(input int n);
    for (int i = 0; i < n; i++) begin
      send(ph, 1'b1);
      ph = ~ph;
      if (gap) send(ph ^ 1'b1, 1'b0);
    end
  endtask

  task automatic flip(input int n);
    for (int i = 0; i < n; i++) begin
      send(~ph, 1'b1);
      ph = ~ph;
    end
  endtask

  task automatic do_reset(input logic start);
    @(negedge clk);
    rst = 1'b1;
    rx_bit_valid = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    ph = start;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset(1'b1);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_rx", rx_count, 32'd0);
    check("rst_err", err_count, 32'd0);

    // clean stream starting with 1
    clean(23);
    check("a_lock23", 32'(locked), 32'd0);
    clean(1);
    check("a_lock24", 32'(locked), 32'd1);
    check("a_rx24", rx_count, 32'd0);
    clean(99);
    check("a_done123", 32'(done), 32'd0);
    check("a_rx123", rx_count, 32'd99);
    clean(1);
    check("a_done", 32'(done), 32'd1);
    check("a_pass", 32'(pass), 32'd1);
    check("a_rx", rx_count, 32'd100);
    check("a_err", err_count, 32'd0);
    for (int i = 0; i < 10; i++) send(1'b0, 1'b1);
    check("a_frz_rx", rx_count, 32'd100);
    check("a_frz_err", err_count, 32'd0);
    check("a_frz_pass", 32'(pass), 32'd1);
    check("a_frz_lock", 32'(locked), 32'd1);

    // stream starting with 0
    do_reset(1'b0);
    clean(8);
    check("b_idx", 32'(dut.idx_q), 32'd6);
    clean(15);
    check("b_lock23", 32'(locked), 32'd0);
    clean(1);
    check("b_lock24", 32'(locked), 32'd1);
    clean(100);
    check("b_done", 32'(done), 32'd1);
    check("b_pass", 32'(pass), 32'd1);
    check("b_rx", rx_count, 32'd100);

    // single flip at locked bit 50
    do_reset(1'b1);
    clean(24 + 49);
    flip(1);
    check("c_err", err_count, 32'd1);
    check("c_lock", 32'(locked), 32'd1);
    clean(50);
    check("c_done", 32'(done), 32'd1);
    check("c_pass", 32'(pass), 32'd0);
    check("c_rx", rx_count, 32'd100);

    // loss of lock at locked bits 30..33
    do_reset(1'b1);
    clean(24 + 29);
    flip(3);
    check("d_lock32", 32'(locked), 32'd1);
    flip(1);
    check("d_loss", 32'(locked), 32'd0);
    check("d_rx33", rx_count, 32'd33);
    check("d_err4", err_count, 32'd4);
    clean(23);
    check("d_relock23", 32'(locked), 32'd0);
    clean(1);
    check("d_relock24", 32'(locked), 32'd1);
    check("d_rxhold", rx_count, 32'd33);
    clean(66);
    check("d_done99", 32'(done), 32'd0);
    clean(1);
    check("d_done", 32'(done), 32'd1);
    check("d_pass", 32'(pass), 32'd0);
    check("d_rx", rx_count, 32'd100);
    check("d_err", err_count, 32'd4);

    // flip at verify match 10
    do_reset(1'b1);
    clean(8 + 9);
    flip(1);
    clean(23);
    check("e_lock23", 32'(locked), 32'd0);
    clean(1);
    check("e_lock24", 32'(locked), 32'd1);

    // valid toggling each cycle
    do_reset(1'b1);
    gap = 1'b1;
    clean(23);
    check("f_lock23", 32'(locked), 32'd0);
    clean(1);
    check("f_lock24", 32'(locked), 32'd1);
    clean(100);
    check("f_done", 32'(done), 32'd1);
    check("f_pass", 32'(pass), 32'd1);
    check("f_rx", rx_count, 32'd100);
    gap = 1'b0;

    // reset pulse mid-LOCKED with valid data present
    do_reset(1'b1);
    clean(40);
    check("g_rx40", rx_count, 32'd16);
    @(negedge clk);
    rst = 1'b1;
    rx_bit_valid = 1'b1;
    rx_bit_data = ph;
    @(posedge clk);
    #1;
    check("g_rst_lock", 32'(locked), 32'd0);
    check("g_rst_rx", rx_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ph = 1'b1;
    clean(23);
    check("g_lock23", 32'(locked), 32'd0);
    clean(1);
    check("g_lock24", 32'(locked), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
